// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the picoMIPS PC sequencer.
// Optional single-step support is enabled with PC_SEQ_SINGLE_STEP_EN.
package pc_seq_pkg;
  typedef enum logic [2:0] {
    RUN, MULTI, WAIT_PRESS, WAIT_RELEASE, HALT, STEP_WAIT
  } seq_state_t;

  localparam int MUL_CYCLES_DEF   = 2;
  localparam int DEBOUNCE_CNT_DEF = 8;

  // Counter width for a modulus n, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability counter; out follows in
// only after DebounceCnt consecutive differing synchronised samples.
module sw_debounce import pc_seq_pkg::*; #(
  parameter int DebounceCnt = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic in,
  output logic out
);
  localparam int CW = cnt_w(DebounceCnt);
  localparam logic [CW-1:0] LAST = CW'(DebounceCnt - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      if (s2 == out)
        cnt <= '0;
      else if (cnt == LAST) begin
        cnt <= '0;
        out <= ~out;
      end else
        cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// PC hold / advance sequencer for multi-cycle, wait-for-switch and halt
// instructions. Define PC_SEQ_SINGLE_STEP_EN to add the Step input.
module pc_sequencer import pc_seq_pkg::*; #(
  parameter int MulCycles   = MUL_CYCLES_DEF,
  parameter int DebounceCnt = DEBOUNCE_CNT_DEF
) (
  input  logic clk,
  input  logic Reset,
  input  logic isMulti,
  input  logic isWait,
  input  logic isHalt,
  input  logic SW,
`ifdef PC_SEQ_SINGLE_STEP_EN
  input  logic Step,
`endif
  output logic PCHold,
  output logic Advance,
  output logic Busy,
  output logic SwStable
);
  localparam int CW = cnt_w(MulCycles);
  localparam logic [CW-1:0] CNT_LOAD = (MulCycles > 1) ? CW'(MulCycles - 2) : '0;

  seq_state_t    state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          step_ok;

  sw_debounce #(.DebounceCnt(DebounceCnt)) u_sw_db (
    .clk(clk), .Reset(Reset), .in(SW), .out(SwStable)
  );

`ifdef PC_SEQ_SINGLE_STEP_EN
  logic step_db, step_prev;

  sw_debounce #(.DebounceCnt(DebounceCnt)) u_step_db (
    .clk(clk), .Reset(Reset), .in(Step), .out(step_db)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) step_prev <= 1'b0;
    else       step_prev <= step_db;
  end

  assign step_ok = step_db & ~step_prev;
`else
  assign step_ok = 1'b1;
`endif

  // Hold is the default; each branch releases the PC only on completion
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    PCHold  = 1'b1;
    case (state)
      RUN: begin
        if (isHalt)
          nxt = HALT;
        else if (isWait)
          nxt = WAIT_PRESS;
        else if (isMulti && (MulCycles > 1)) begin
          nxt     = MULTI;
          cnt_nxt = CNT_LOAD;
        end else begin
`ifdef PC_SEQ_SINGLE_STEP_EN
          nxt = STEP_WAIT;
`else
          PCHold = 1'b0;
`endif
        end
      end
      MULTI: begin
        if (cnt != '0)
          cnt_nxt = cnt - 1'b1;
        else if (step_ok) begin
          PCHold = 1'b0;
          nxt    = RUN;
        end
      end
      WAIT_PRESS: if (SwStable) nxt = WAIT_RELEASE;
      WAIT_RELEASE: begin
        if (!SwStable && step_ok) begin
          PCHold = 1'b0;
          nxt    = RUN;
        end
      end
`ifdef PC_SEQ_SINGLE_STEP_EN
      STEP_WAIT: begin
        if (step_ok) begin
          PCHold = 1'b0;
          nxt    = RUN;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign Advance = ~PCHold;
  assign Busy    = (state != RUN);
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (MulCycles=3, DebounceCnt=8) with a
// per-cycle expectation queue.
module tb_pc_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic is_multi = 1'b0, is_wait = 1'b0, is_halt = 1'b0, sw = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic pc_hold, advance, busy, sw_stable;

  int checks = 0, errors = 0;

  typedef struct {
    logic  hold;
    logic  bsy;
    logic  swv;
    bit    use_sw;
    string tag;
  } exp_t;
  exp_t sb[$];

  pc_sequencer #(.MulCycles(3), .DebounceCnt(8)) dut (
    .clk(clk), .Reset(rst), .isMulti(is_multi), .isWait(is_wait),
    .isHalt(is_halt), .SW(sw),
`ifdef PC_SEQ_SINGLE_STEP_EN
    .Step(step),
`endif
    .PCHold(pc_hold), .Advance(advance), .Busy(busy), .SwStable(sw_stable)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    exp_t e;
    #2;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard empty got 0 entries want 1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (pc_hold === e.hold) else begin
        errors++;
        $error("FAIL %s PCHold got %b want %b", e.tag, pc_hold, e.hold);
      end
      checks++;
      assert (advance === ~e.hold) else begin
        errors++;
        $error("FAIL %s Advance got %b want %b", e.tag, advance, ~e.hold);
      end
      checks++;
      assert (busy === e.bsy) else begin
        errors++;
        $error("FAIL %s Busy got %b want %b", e.tag, busy, e.bsy);
      end
      if (e.use_sw) begin
        checks++;
        assert (sw_stable === e.swv) else begin
          errors++;
          $error("FAIL %s SwStable got %b want %b", e.tag, sw_stable, e.swv);
        end
      end
    end
  endtask

  task automatic chk(input logic h, input logic b, input logic s,
                     input bit us, input string t);
    sb.push_back('{h, b, s, us, t});
    observe();
  endtask

  initial begin
    // reset state
    #1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    #3 rst = 1'b0;
    tick();
    chk(1'b0, 1'b0, 1'b0, 1'b1, "plain");

    // multi-cycle, 3 cycles total
    is_multi = 1'b1;
    chk(1'b1, 1'b0, 1'b0, 1'b1, "multi_c1");
    tick();
    chk(1'b1, 1'b1, 1'b0, 1'b1, "multi_c2");
    tick();
    chk(1'b0, 1'b1, 1'b0, 1'b1, "multi_c3");
    tick();
    is_multi = 1'b0;
    chk(1'b0, 1'b0, 1'b0, 1'b1, "multi_done");

    // reset in the middle of a multi-cycle instruction
    is_multi = 1'b1;
    tick();
    is_multi = 1'b0;
    chk(1'b1, 1'b1, 1'b0, 1'b1, "mid_multi");
    rst = 1'b1;
    #1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, "mid_multi_rst");
    rst = 1'b0;
    tick();
    chk(1'b0, 1'b0, 1'b0, 1'b1, "post_rst_plain");

    // wait for press and release
    is_wait = 1'b1;
    chk(1'b1, 1'b0, 1'b0, 1'b1, "wait_enter");
    tick();
    is_wait = 1'b0;
    sw = 1'b1;
    for (int k = 1; k < 50; k++) begin
      tick();
      if (k == 40) sw = 1'b0;
      chk(1'b1, 1'b1, (k >= 10), 1'b1, "wait_hold");
    end
    tick();
    chk(1'b0, 1'b1, 1'b0, 1'b1, "wait_release");
    tick();
    chk(1'b0, 1'b0, 1'b0, 1'b1, "wait_done");

    // short glitch during WAIT_PRESS is rejected
    is_wait = 1'b1;
    chk(1'b1, 1'b0, 1'b0, 1'b1, "glitch_enter");
    tick();
    is_wait = 1'b0;
    sw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) sw = 1'b0;
      chk(1'b1, 1'b1, 1'b0, 1'b1, "glitch");
    end
    rst = 1'b1;
    #1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, "glitch_rst");
    rst = 1'b0;
    tick();

    // halt has priority over wait and ignores the switch
    is_halt = 1'b1;
    is_wait = 1'b1;
    chk(1'b1, 1'b0, 1'b0, 1'b1, "halt_enter");
    tick();
    is_halt = 1'b0;
    is_wait = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (k % 15 == 0) sw = ~sw;
      chk(1'b1, 1'b1, 1'b0, 1'b0, "halt");
    end
    sw = 1'b0;
    rst = 1'b1;
    #1;
    chk(1'b0, 1'b0, 1'b0, 1'b1, "halt_rst");
    rst = 1'b0;
    tick();
    chk(1'b0, 1'b0, 1'b0, 1'b1, "post_halt");

`ifdef PC_SEQ_SINGLE_STEP_EN
    begin
      int adv_cnt;
      adv_cnt = 0;
      tick();
      for (int p = 0; p < 3; p++) begin
        step = 1'b1;
        for (int k = 1; k <= 40; k++) begin
          tick();
          if (k == 20) step = 1'b0;
          if (advance === 1'b1) adv_cnt++;
          chk((k != 10), (k <= 10), 1'b0, 1'b0, "step");
        end
      end
      checks++;
      assert (adv_cnt == 3) else begin
        errors++;
        $error("FAIL step_count got %0d want 3", adv_cnt);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
